// File: rtl/sample_mem_arbiter_pkg.sv
// Shared constants for the scanout/capture sample RAM arbiter.
// Default geometry, swap FSM state codes and a small edge-detect helper.
package sample_mem_arbiter_pkg;

  localparam int unsigned H_ACTIVE       = 640;
  localparam int unsigned V_ACTIVE       = 480;
  localparam int unsigned POS_W          = 16;
  localparam int unsigned DEF_ADDR_W     = 10;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  localparam int unsigned ST_W = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sample_mem_arbiter_if.sv
// Capture-writer request channel into the sample RAM arbiter.
interface sample_mem_arbiter_if
  import sample_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/sample_mem_arbiter_fifo.sv
// Small synchronous FIFO buffering capture writes until the RAM port is free.
// Head is read combinationally; full/empty are registered alongside the count.
module sample_wr_fifo
  import sample_mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset; only the pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == CNT_W'(0));
    end
  end

endmodule

// File: rtl/sample_mem_arbiter.sv
// Shares one single-port, double-banked sample RAM between VGA scanout (front bank)
// and the buffered capture writer (back bank), with a vblank-synchronous bank swap.
module sample_mem_arbiter
  import sample_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [POS_W-1:0]    pos_x,
  input  logic                blank_n,
  input  logic                sync_v,
  sample_mem_arbiter_if.slave wr,
  input  logic                swap_req,
  output logic                swap_done,
  output logic                front_bank,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W:0]     ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   disp_sample,
  output logic                disp_valid
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head_c;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               grant_rd;
  logic               grant_wr;

  logic               sync_v_d;
  logic               vsync_rise;
  logic [ST_W-1:0]    state;
  logic [ST_W-1:0]    state_nxt;
  logic               pending;
  logic               pending_nxt;
  logic               flip;
  logic [1:0]         blank_d;
  logic               unused_pos;

  // Column count beyond the sample index is don't-care.
  assign unused_pos = ^pos_x[POS_W-1:ADDR_W];

  sample_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr.wr_valid),
    .push_data ({wr.wr_addr, wr.wr_data}),
    .pop       (grant_wr),
    .head_c    (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr.wr_ready = ~fifo_full;
  assign head_addr   = head_c[ENTRY_W-1:DATA_W];
  assign head_data   = head_c[DATA_W-1:0];

  // Scanout owns the port for the whole active line; writes only fill the gaps.
  assign grant_rd   = blank_n;
  assign grant_wr   = ~blank_n & ~fifo_empty;
  assign vsync_rise = rise(sync_v, sync_v_d);

  always_comb begin
    state_nxt = state;
    flip      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (vsync_rise && pending) begin
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (blank_n) begin
          state_nxt = ST_IDLE;
        end else if (fifo_empty && !grant_wr) begin
          state_nxt = ST_SWAP;
          flip      = 1'b1;
        end
      end
      ST_SWAP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // A request landing on the flip cycle belongs to the next frame.
    pending_nxt = flip ? swap_req : (pending | swap_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      sync_v_d   <= 1'b0;
      front_bank <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      sync_v_d   <= sync_v;
      front_bank <= front_bank ^ flip;
      swap_done  <= flip;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= grant_rd | grant_wr;
      ram_we <= grant_wr;
      if (grant_rd) begin
        ram_addr <= {front_bank, pos_x[ADDR_W-1:0]};
      end else if (grant_wr) begin
        ram_addr  <= {~front_bank, head_addr};
        ram_wdata <= head_data;
      end
    end
  end

  // blank_n travels alongside the read: address, RAM latency, output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_d     <= '0;
      disp_valid  <= 1'b0;
      disp_sample <= '0;
    end else begin
      blank_d     <= {blank_d[0], blank_n};
      disp_valid  <= blank_d[1];
      disp_sample <= ram_rdata;
    end
  end

  ap_write_back_only: assert property (@(posedge clk) disable iff (rst)
    ram_we |-> (ram_addr[ADDR_W] != front_bank));

  ap_we_needs_en: assert property (@(posedge clk) disable iff (rst)
    ram_we |-> ram_en);

  ap_done_single: assert property (@(posedge clk) disable iff (rst)
    swap_done |=> !swap_done);

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// Directed bench for sample_mem_arbiter: behavioural RAM, queue-based model of the
// grant/FIFO/swap rules, a per-cycle compare process and hand-computed spot checks.
module tb_sample_mem_arbiter;
  import sample_mem_arbiter_pkg::*;

  localparam int unsigned AW    = DEF_ADDR_W;
  localparam int unsigned DW    = DEF_DATA_W;
  localparam int unsigned DEPTH = DEF_FIFO_DEPTH;
  localparam int unsigned NWORD = 2 ** (AW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   pos_x;
  logic          blank_n;
  logic          sync_v;
  logic          swap_req;
  logic          swap_done;
  logic          front_bank;
  logic          ram_en;
  logic          ram_we;
  logic [AW:0]   ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] disp_sample;
  logic          disp_valid;

  sample_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) wr_if ();

  sample_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .pos_x       (pos_x),
    .blank_n     (blank_n),
    .sync_v      (sync_v),
    .wr          (wr_if),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .front_bank  (front_bank),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .disp_sample (disp_sample),
    .disp_valid  (disp_valid)
  );

  always #5 clk = ~clk;

  // Bank 0 holds i, bank 1 holds i^A5, in both the RAM and the model's copy.
  function automatic logic [DW-1:0] preload(input int i);
    logic [DW-1:0] v;
    v = DW'(i);
    return (i >= (2 ** AW)) ? (v ^ 8'hA5) : v;
  endfunction

  logic [DW-1:0] ram [NWORD];
  bit            ram_loaded;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < NWORD; i++) ram[i] <= preload(i);
      ram_loaded <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  // Behavioural model: queue of pending writes, bank flag, swap request/arm flags.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q [$];
  wr_t           h;
  logic [DW-1:0] mm [NWORD];
  bit            mm_loaded;
  bit            m_front, m_pending, m_armed, m_hold, m_sv, vr;
  int            n;
  bit            e_en, e_we, e_done, e_rdy;
  logic [AW:0]   e_addr;
  logic [DW-1:0] e_wdata;
  bit            dv1, dv2, dv3;
  logic [DW-1:0] ds1, ds2, ds3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (!mm_loaded) begin
        for (int i = 0; i < NWORD; i++) mm[i] = preload(i);
        mm_loaded = 1'b1;
      end
      q.delete();
      m_front = 0; m_pending = 0; m_armed = 0; m_hold = 0; m_sv = 0;
      e_en = 0; e_we = 0; e_done = 0; e_rdy = 1; e_addr = '0; e_wdata = '0;
      dv1 = 0; dv2 = 0; dv3 = 0; ds1 = '0; ds2 = '0; ds3 = '0;
    end else begin
      n    = q.size();
      vr   = sync_v && !m_sv;
      m_sv = sync_v;
      dv3 = dv2; dv2 = dv1; dv1 = blank_n;
      ds3 = ds2; ds2 = ds1;
      e_en = 0; e_we = 0;
      if (blank_n) begin
        e_en   = 1;
        e_addr = {m_front, pos_x[AW-1:0]};
        ds1    = mm[e_addr];
      end else if (n > 0) begin
        h       = q.pop_front();
        e_en    = 1;
        e_we    = 1;
        e_addr  = {~m_front, h.a};
        e_wdata = h.d;
        mm[e_addr] = h.d;
      end
      if (wr_if.wr_valid && n < DEPTH) q.push_back({wr_if.wr_addr, wr_if.wr_data});
      e_rdy  = (q.size() < DEPTH);
      e_done = 0;
      if (m_armed) begin
        if (blank_n) m_armed = 0;
        else if (n == 0) begin
          m_front = !m_front;
          e_done  = 1;
          m_armed = 0;
        end
      end else if (!m_hold && vr && m_pending) begin
        m_armed = 1;
      end
      m_hold    = e_done;
      m_pending = e_done ? swap_req : (m_pending | swap_req);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("wr_ready",   32'(wr_if.wr_ready), 32'(e_rdy));
        chk("front_bank", 32'(front_bank),     32'(m_front));
        chk("swap_done",  32'(swap_done),      32'(e_done));
        chk("ram_en",     32'(ram_en),         32'(e_en));
        chk("ram_we",     32'(ram_we),         32'(e_we));
        if (e_en) chk("ram_addr",  32'(ram_addr),  32'(e_addr));
        if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        chk("disp_valid", 32'(disp_valid), 32'(dv3));
        if (dv3) chk("disp_sample", 32'(disp_sample), 32'(ds3));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int budget;
    budget = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    while (!wr_if.wr_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (budget >= 50) chk("push_timeout", 32'(wr_if.wr_ready), 32'd1);
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pos_x = '0; blank_n = 1'b0; sync_v = 1'b0; swap_req = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
    fork compare_loop(); join_none
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_wr_ready",   32'(wr_if.wr_ready), 32'd1);
    chk("rst_front",      32'(front_bank),     32'd0);
    chk("rst_ram_en",     32'(ram_en),         32'd0);
    chk("rst_disp_valid", 32'(disp_valid),     32'd0);

    // One active line from bank 0, then two blanking cycles
    for (int k = 0; k < 642; k++) begin
      blank_n = (k < 640);
      pos_x   = 16'(k);
      tick();
      if (k == 2)   chk("line_px0",   32'(disp_sample), 32'd0);
      if (k == 299) chk("line_px297", 32'(disp_sample), 32'd41);
      if (k == 641) begin
        chk("line_px639",   32'(disp_sample), 32'd127);
        chk("line_valid639", 32'(disp_valid), 32'd1);
      end
    end

    // Six writes during active video: four fill the FIFO, the rest wait for hblank
    blank_n = 1'b1; pos_x = 16'd100;
    for (int j = 0; j < 4; j++) push(AW'(10 + j), DW'(8'h30 + j));
    chk("fifo_full_ready", 32'(wr_if.wr_ready), 32'd0);
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = AW'(14); wr_if.wr_data = 8'h34;
    tick(); tick();
    chk("active_no_we", 32'(ram_we), 32'd0);
    chk("still_full",   32'(wr_if.wr_ready), 32'd0);
    blank_n = 1'b0;
    tick();
    chk("hblank_we",    32'(ram_we),    32'd1);
    chk("hblank_addr0", 32'(ram_addr),  32'h40A);
    chk("hblank_data0", 32'(ram_wdata), 32'h30);
    tick();
    wr_if.wr_valid = 1'b0;
    push(AW'(15), 8'h35);
    repeat (6) tick();

    // Swap request with three writes queued; swap waits for the drain after vsync
    blank_n = 1'b1; pos_x = 16'd200;
    for (int j = 0; j < 3; j++) push(AW'(20 + j), DW'(8'h50 + j));
    pulse_swap();
    tick();
    blank_n = 1'b0; sync_v = 1'b1;
    tick(); tick(); tick();
    chk("swap_not_yet", 32'(swap_done), 32'd0);
    tick();
    chk("swap_done_t4", 32'(swap_done),  32'd1);
    chk("front_t4",     32'(front_bank), 32'd1);
    tick();
    sync_v = 1'b0;
    repeat (3) tick();
    blank_n = 1'b1; pos_x = 16'hFC05;
    tick();
    chk("next_frame_addr", 32'(ram_addr), 32'h405);
    repeat (3) tick();

    // Request on the vsync edge itself is deferred one frame
    blank_n = 1'b0;
    tick();
    sync_v = 1'b1; swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (5) tick();
    chk("deferred_front", 32'(front_bank), 32'd1);
    sync_v = 1'b0; blank_n = 1'b1;
    for (int k = 0; k < 20; k++) begin pos_x = 16'(k); tick(); end
    blank_n = 1'b0;
    tick();
    sync_v = 1'b1;
    tick(); tick();
    chk("deferred_done",  32'(swap_done),  32'd1);
    chk("deferred_front2", 32'(front_bank), 32'd0);
    tick();

    // Two requests in one frame coalesce into one swap
    sync_v = 1'b0; blank_n = 1'b1; pos_x = 16'd7;
    pulse_swap(); tick(); pulse_swap();
    blank_n = 1'b0;
    tick();
    sync_v = 1'b1;
    tick(); tick();
    chk("coalesce_front", 32'(front_bank), 32'd1);
    sync_v = 1'b0; repeat (3) tick();
    sync_v = 1'b1; repeat (4) tick();
    chk("coalesce_once", 32'(front_bank), 32'd1);

    // Active video returns before the drain: swap abandoned, request kept
    sync_v = 1'b0; blank_n = 1'b1; pos_x = 16'd30;
    tick();
    for (int j = 0; j < 4; j++) push(AW'(40 + j), DW'(8'h70 + j));
    pulse_swap();
    blank_n = 1'b0; sync_v = 1'b1;
    tick();
    blank_n = 1'b1;
    tick();
    blank_n = 1'b0;
    repeat (5) tick();
    chk("abort_front", 32'(front_bank), 32'd1);
    sync_v = 1'b0;
    tick();

    // Reset while a write is on the port and two entries remain
    blank_n = 1'b1; pos_x = 16'd50;
    for (int j = 0; j < 3; j++) push(AW'(60 + j), DW'(8'h90 + j));
    blank_n = 1'b0;
    tick();
    chk("pre_rst_we", 32'(ram_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_we",    32'(ram_we),          32'd0);
    chk("rst_ready", 32'(wr_if.wr_ready),  32'd1);
    chk("rst_front2", 32'(front_bank),     32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_fifo_empty", 32'(ram_en), 32'd0);
    sync_v = 1'b1;
    repeat (4) tick();
    chk("rst_pending_clear", 32'(front_bank), 32'd0);
    sync_v = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
